// File: rtl/buzzer_round_ctrl.sv
// Three-team quiz round controller: synchronized inputs, first-press buzzer
// arbitration, round FSM, per-team BCD scores and display digit outputs.
module buzzer_round_ctrl #(
    parameter int unsigned ANSWER_CYCLES   = 500_000_000,
    parameter int unsigned COOLDOWN_CYCLES = 100_000_000,
    parameter int unsigned TMR_W           = 29
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [2:0] buzz,
    input  logic       start_btn,
    input  logic       correct_btn,
    input  logic       wrong_btn,
    input  logic       clear_btn,
    output logic [1:0] state,
    output logic [2:0] thousands,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [2:0] lockout
);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StArmed    = 2'b01,
        StLocked   = 2'b10,
        StCooldown = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [6:0]       w_raw;
    logic [6:0]       r_sync1;
    logic [6:0]       r_sync2;
    logic [3:0]       r_btn_prev;
    logic [3:0]       w_btn_rise;
    logic             w_start_p;
    logic             w_correct_p;
    logic             w_wrong_p;
    logic             w_clear_p;
    logic [2:0]       w_buzz_s;
    logic [2:0]       w_eligible;
    logic [2:0]       w_winner_nxt;
    logic [2:0]       w_lock_new;
    logic [TMR_W-1:0] r_tmr;
    logic             w_timeout;
    logic             w_cd_done;
    logic [2:0]       r_thousands;
    logic [2:0]       r_lockout;
    logic [3:0]       r_sc_tens [3];
    logic [3:0]       r_sc_ones [3];
    logic [3:0]       r_disp_tens;
    logic [3:0]       r_disp_ones;
    logic [3:0]       w_sel_tens;
    logic [3:0]       w_sel_ones;
    logic [3:0]       w_inc_tens;
    logic [3:0]       w_inc_ones;
    logic [3:0]       w_dec_tens;
    logic [3:0]       w_dec_ones;
    logic             w_do_inc;
    logic             w_do_dec;
    logic             w_do_clear;
    logic             w_do_lock;
    logic             w_do_arm;
    logic             w_tmr_clr;

    // Bits 6:4 buzzers, 3 start, 2 correct, 1 wrong, 0 clear.
    assign w_raw       = {buzz, start_btn, correct_btn, wrong_btn, clear_btn};
    assign w_btn_rise  = r_sync2[3:0] & ~r_btn_prev;
    assign w_start_p   = w_btn_rise[3];
    assign w_correct_p = w_btn_rise[2];
    assign w_wrong_p   = w_btn_rise[1];
    assign w_clear_p   = w_btn_rise[0];
    assign w_buzz_s    = r_sync2[6:4];

    assign w_eligible   = w_buzz_s & ~r_lockout;
    assign w_winner_nxt = w_eligible[2] ? 3'b100 : (w_eligible[1] ? 3'b010 : 3'b001);
    assign w_lock_new   = r_lockout | r_thousands;
    assign w_timeout    = (r_tmr == TMR_W'(ANSWER_CYCLES - 1));
    assign w_cd_done    = (r_tmr == TMR_W'(COOLDOWN_CYCLES - 1));

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_btn_prev <= '0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_btn_prev <= r_sync2[3:0];
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:     if (w_start_p) w_state_d = StArmed;
            StArmed:    if (|w_eligible) w_state_d = StLocked;
            StLocked: begin
                if (w_correct_p) begin
                    w_state_d = StCooldown;
                end else if (w_wrong_p || w_timeout) begin
                    w_state_d = (w_lock_new == 3'b111) ? StCooldown : StArmed;
                end
            end
            StCooldown: if (w_cd_done) w_state_d = StIdle;
            default:    w_state_d = StIdle;
        endcase
    end

    always_comb begin
        state      = r_state;
        thousands  = r_thousands;
        tens       = r_disp_tens;
        ones       = r_disp_ones;
        lockout    = r_lockout;
        w_do_arm   = (r_state == StIdle) && w_start_p;
        w_do_clear = (r_state == StIdle) && w_clear_p;
        w_do_lock  = (r_state == StArmed) && (|w_eligible);
        w_do_inc   = (r_state == StLocked) && w_correct_p;
        w_do_dec   = (r_state == StLocked) && !w_correct_p && (w_wrong_p || w_timeout);
        w_tmr_clr  = (w_state_d != r_state);
    end

    // thousands is one-hot or zero, so OR-reduction selects the shown score.
    always_comb begin
        w_sel_tens = '0;
        w_sel_ones = '0;
        for (int i = 0; i < 3; i++) begin
            if (r_thousands[i]) begin
                w_sel_tens = w_sel_tens | r_sc_tens[i];
                w_sel_ones = w_sel_ones | r_sc_ones[i];
            end
        end
    end

    always_comb begin
        w_inc_tens = w_sel_tens;
        w_inc_ones = w_sel_ones;
        if (!(w_sel_tens == 4'd9 && w_sel_ones == 4'd9)) begin
            if (w_sel_ones == 4'd9) begin
                w_inc_ones = 4'd0;
                w_inc_tens = w_sel_tens + 4'd1;
            end else begin
                w_inc_ones = w_sel_ones + 4'd1;
            end
        end
        w_dec_tens = w_sel_tens;
        w_dec_ones = w_sel_ones;
        if (!(w_sel_tens == 4'd0 && w_sel_ones == 4'd0)) begin
            if (w_sel_ones == 4'd0) begin
                w_dec_ones = 4'd9;
                w_dec_tens = w_sel_tens - 4'd1;
            end else begin
                w_dec_ones = w_sel_ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_tmr       <= '0;
            r_thousands <= '0;
            r_lockout   <= '0;
            r_disp_tens <= '0;
            r_disp_ones <= '0;
            for (int i = 0; i < 3; i++) begin
                r_sc_tens[i] <= '0;
                r_sc_ones[i] <= '0;
            end
        end else begin
            if (w_tmr_clr) begin
                r_tmr <= '0;
            end else if (r_state == StLocked || r_state == StCooldown) begin
                r_tmr <= r_tmr + 1'b1;
            end

            if (w_do_arm) begin
                r_lockout <= '0;
            end else if (w_do_dec) begin
                r_lockout <= w_lock_new;
            end

            if (w_do_clear) begin
                r_thousands <= '0;
            end else if (w_do_lock) begin
                r_thousands <= w_winner_nxt;
            end

            for (int i = 0; i < 3; i++) begin
                if (w_do_clear) begin
                    r_sc_tens[i] <= '0;
                    r_sc_ones[i] <= '0;
                end else if (r_thousands[i] && w_do_inc) begin
                    r_sc_tens[i] <= w_inc_tens;
                    r_sc_ones[i] <= w_inc_ones;
                end else if (r_thousands[i] && w_do_dec) begin
                    r_sc_tens[i] <= w_dec_tens;
                    r_sc_ones[i] <= w_dec_ones;
                end
            end

            r_disp_tens <= w_sel_tens;
            r_disp_ones <= w_sel_ones;
        end
    end

endmodule

// File: tb/tb_buzzer_round_ctrl.sv
// Directed bench for buzzer_round_ctrl with short answer/cooldown timers.
module tb_buzzer_round_ctrl;

    localparam int START   = 0;
    localparam int CORRECT = 1;
    localparam int WRONG   = 2;
    localparam int CLEAR   = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] buzz;
    logic       start_btn;
    logic       correct_btn;
    logic       wrong_btn;
    logic       clear_btn;
    logic [1:0] state;
    logic [2:0] thousands;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [2:0] lockout;

    int checks = 0;
    int errors = 0;

    buzzer_round_ctrl #(
        .ANSWER_CYCLES  (16),
        .COOLDOWN_CYCLES(8),
        .TMR_W          (5)
    ) u_dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .buzz       (buzz),
        .start_btn  (start_btn),
        .correct_btn(correct_btn),
        .wrong_btn  (wrong_btn),
        .clear_btn  (clear_btn),
        .state      (state),
        .thousands  (thousands),
        .tens       (tens),
        .ones       (ones),
        .lockout    (lockout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Button pulse; returns on the negedge just after the action edge.
    task automatic press(input int k);
        case (k)
            START:   start_btn = 1'b1;
            CORRECT: correct_btn = 1'b1;
            WRONG:   wrong_btn = 1'b1;
            default: clear_btn = 1'b1;
        endcase
        tick(1);
        start_btn   = 1'b0;
        correct_btn = 1'b0;
        wrong_btn   = 1'b0;
        clear_btn   = 1'b0;
        tick(2);
    endtask

    task automatic round_ok(input logic [2:0] b);
        press(START);
        buzz = b;
        tick(3);
        buzz = 3'b000;
        press(CORRECT);
        tick(8);
    endtask

    initial begin
        reset_n     = 1'b1;
        buzz        = 3'b000;
        start_btn   = 1'b0;
        correct_btn = 1'b0;
        wrong_btn   = 1'b0;
        clear_btn   = 1'b0;
        #1 reset_n  = 1'b0;
        tick(2);
        check("rst_state", state, 2'b00);
        check("rst_thousands", thousands, 3'b000);
        check("rst_tens", tens, 4'd0);
        check("rst_ones", ones, 4'd0);
        check("rst_lockout", lockout, 3'b000);
        reset_n = 1'b1;
        tick(1);

        // B alone, correct, cooldown back to idle
        press(START);
        check("arm_state", state, 2'b01);
        buzz = 3'b010;
        tick(3);
        buzz = 3'b000;
        check("lockB_state", state, 2'b10);
        check("lockB_th", thousands, 3'b010);
        press(CORRECT);
        check("corr_state", state, 2'b11);
        tick(1);
        check("corrB_tens", tens, 4'd0);
        check("corrB_ones", ones, 4'd1);
        tick(6);
        check("cool_hold", state, 2'b11);
        tick(1);
        check("cool_done", state, 2'b00);
        check("idle_th_hold", thousands, 3'b010);

        // buzz in idle ignored
        buzz = 3'b111;
        tick(4);
        check("idle_buzz", state, 2'b00);
        buzz = 3'b000;
        tick(2);

        // A and C same cycle, A wins; wrong -> C takes over
        press(START);
        buzz = 3'b101;
        tick(3);
        check("tie_state", state, 2'b10);
        check("tie_th", thousands, 3'b100);
        buzz = 3'b001;
        press(WRONG);
        check("wrongA_state", state, 2'b01);
        check("wrongA_lock", lockout, 3'b100);
        tick(1);
        check("lockC_state", state, 2'b10);
        check("lockC_th", thousands, 3'b001);
        check("A_sat_ones", ones, 4'd0);
        check("A_sat_tens", tens, 4'd0);
        buzz = 3'b000;

        // C times out on cycle 16
        tick(15);
        check("toC_before", state, 2'b10);
        tick(1);
        check("toC_state", state, 2'b01);
        check("toC_lock", lockout, 3'b101);

        // B times out -> all locked out -> cooldown
        buzz = 3'b010;
        tick(3);
        buzz = 3'b000;
        check("lockB2_th", thousands, 3'b010);
        tick(16);
        check("all_lock", lockout, 3'b111);
        check("all_state", state, 2'b11);
        tick(1);
        check("toB_ones", ones, 4'd0);
        buzz = 3'b111;
        tick(4);
        check("cool_buzz", state, 2'b11);
        buzz = 3'b000;
        tick(3);
        check("cool_idle2", state, 2'b00);
        tick(2);

        // BCD carry at 09 -> 10
        for (int i = 0; i < 9; i++) round_ok(3'b010);
        check("B09_tens", tens, 4'd0);
        check("B09_ones", ones, 4'd9);
        round_ok(3'b010);
        check("B10_tens", tens, 4'd1);
        check("B10_ones", ones, 4'd0);

        // BCD borrow at 10 -> 09
        press(START);
        buzz = 3'b010;
        tick(3);
        buzz = 3'b000;
        press(WRONG);
        check("B_wr_state", state, 2'b01);
        check("B_wr_lock", lockout, 3'b010);
        tick(1);
        check("B09b_tens", tens, 4'd0);
        check("B09b_ones", ones, 4'd9);
        buzz = 3'b100;
        tick(3);
        buzz = 3'b000;
        check("lockA_th", thousands, 3'b100);
        press(CORRECT);
        tick(8);
        check("A_idle", state, 2'b00);

        // saturate at 99
        for (int i = 0; i < 90; i++) round_ok(3'b010);
        check("B99_tens", tens, 4'd9);
        check("B99_ones", ones, 4'd9);
        round_ok(3'b010);
        check("B99s_tens", tens, 4'd9);
        check("B99s_ones", ones, 4'd9);

        // clear ignored in LOCKED, honoured in IDLE
        press(START);
        buzz = 3'b010;
        tick(3);
        buzz = 3'b000;
        press(CLEAR);
        check("clrL_state", state, 2'b10);
        check("clrL_tens", tens, 4'd9);
        check("clrL_ones", ones, 4'd9);
        press(CORRECT);
        tick(8);
        press(CLEAR);
        check("clr_th", thousands, 3'b000);
        tick(1);
        check("clr_tens", tens, 4'd0);
        check("clr_ones", ones, 4'd0);
        round_ok(3'b010);
        check("clrB_tens", tens, 4'd0);
        check("clrB_ones", ones, 4'd1);

        // asynchronous reset mid-LOCKED
        press(START);
        buzz = 3'b010;
        tick(3);
        buzz = 3'b000;
        check("pre_rst_state", state, 2'b10);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_state", state, 2'b00);
        check("arst_th", thousands, 3'b000);
        check("arst_lock", lockout, 3'b000);
        check("arst_ones", ones, 4'd0);
        tick(1);
        reset_n = 1'b1;
        tick(1);
        press(START);
        buzz = 3'b010;
        tick(3);
        buzz = 3'b000;
        check("post_rst_th", thousands, 3'b010);
        tick(1);
        check("post_rst_ones", ones, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzzer_round_ctrl.md
Name: buzzer_round_ctrl

Overview:
- Quiz-round controller for the three-team buzzer scoring system.
- Arbitrates team buzzers with first-press priority and runs the round state machine (idle / armed / locked / cooldown).
- Keeps one BCD score per team, applies host correct/wrong verdicts with an answer timeout, and drives state, winner one-hot and score digits for the 4-digit seven-segment display driver.

Parameters:
- ANSWER_CYCLES, 500_000_000, clock cycles a locked team has to answer (5 s at 100 MHz); expiry counts as wrong.
- COOLDOWN_CYCLES, 100_000_000, cycles spent in COOLDOWN after a verdict before returning to IDLE (1 s).
- TMR_W, 29, answer/cooldown timer width; must hold max(ANSWER_CYCLES, COOLDOWN_CYCLES).

Ports:
- clk_100MHz  in  1  system clock, 100 MHz
- reset_n  in  1  asynchronous active-low reset
- buzz  in  3  raw team buzzers, active high; bit2=team A, bit1=team B, bit0=team C
- start_btn  in  1  host: arm round, raw
- correct_btn  in  1  host: verdict correct, raw
- wrong_btn  in  1  host: verdict wrong, raw
- clear_btn  in  1  host: clear all scores (IDLE only), raw
- state  out  2  00 IDLE, 01 ARMED, 10 LOCKED, 11 COOLDOWN
- thousands  out  3  one-hot displayed team (100 A, 010 B, 001 C), 000 = none
- tens  out  4  BCD tens of displayed team's score
- ones  out  4  BCD ones of displayed team's score
- lockout  out  3  teams barred for the current question

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous, active-low, and clears all state immediately.
- Reset values: state=00, thousands=000, tens=0, ones=0, lockout=000, all scores 00, timer 0, all synchronizer flops 0.
- Input conditioning:
  - All 7 raw inputs pass through a 2-flop synchronizer.
  - Host buttons use a rising-edge detect on the synchronized signal, giving a 1-cycle pulse.
  - Buzzers are level-sampled once synchronized.
  - Input-to-action latency is 3 cycles.
- IDLE:
  - Buzzers are ignored, so there is no false-start penalty.
  - clear_btn pulse zeroes all three scores and sets thousands=000.
  - start_btn pulse goes to ARMED and sets lockout=000.
- ARMED:
  - The controller evaluates eligible = buzz_sync & ~lockout each cycle.
  - If eligible != 0, go to LOCKED and latch the winner as the highest-priority set bit (A > B > C); the winner is one-hot.
  - Winner priority applies only to same-cycle presses; an earlier press always wins.
  - On entry to LOCKED, the timer loads 0.
  - start_btn in ARMED is ignored.
- LOCKED:
  - thousands = winner; the timer increments each cycle.
  - correct_btn pulse: winner score += 1 in BCD (ones 9 wraps to 0 with a tens carry; 99 saturates at 99). Then go to COOLDOWN.
  - wrong_btn pulse, or timer == ANSWER_CYCLES-1: winner score -= 1 in BCD (00 saturates at 00), and the winner bit is set in lockout.
    - If the new lockout == 111, go to COOLDOWN.
    - Otherwise return to ARMED.
  - correct and wrong in the same cycle: correct wins and wrong is dropped.
  - A verdict in the same cycle as the timeout: the verdict wins.
- COOLDOWN:
  - thousands stays at the last winner; buzzers and host buttons are ignored.
  - Go to IDLE after COOLDOWN_CYCLES.
- Display outputs:
  - tens/ones always show the score of the team in thousands, registered and updated the cycle after any score change.
  - When thousands=000, tens/ones = 0.
  - thousands holds its value through IDLE until the next lock or a clear.
- Score storage: per team, two 4-bit BCD digits. Only the winner's score is modified, and only in LOCKED.
- Reset mid-operation: an asynchronous return to all reset values from any state; a pending timer is discarded.

Test Plan:
- Reset, then start, then B buzzes alone → after 3-cycle sync: state=10, thousands=010. correct → B score 01, state=11, then IDLE after COOLDOWN_CYCLES; tens/ones=0/1.
- A and C assert buzz in the same cycle while ARMED → thousands=100 (A wins). Wrong → lockout=100, state=01, A score stays 00 (saturated). C still held → next lock thousands=001.
- Team locked to score 09, correct → 10 (ones=0, tens=1). Score 99, correct → stays 99. Score 10, wrong → 09.
- LOCKED with no verdict for ANSWER_CYCLES (set to 16 in bench) → treated as wrong on cycle 16; lockout updated. All three time out in turn → lockout=111, state=11.
- Buzz in IDLE/COOLDOWN → no state change. clear_btn in IDLE → all scores 00, thousands=000. clear_btn in LOCKED → ignored.
- reset_n pulsed low mid-LOCKED, asynchronous to the clock → outputs zero immediately without a clock edge; scores 00, state=00.
